// File: rtl/card_dealer.sv
// Card source for the bell game: deals LFSR-derived card pairs, runs the
// reward countdown, holds while a press resolves, and ends after MAX_ROUNDS.
module card_dealer #(
    parameter logic [7:0]  COUNT_INIT = 8'd100,
    parameter logic [7:0]  MAX_ROUNDS = 8'd10,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       finish,
    output logic [1:0] c1,
    output logic [2:0] n1,
    output logic [1:0] c2,
    output logic [2:0] n2,
    output logic [7:0] count,
    output logic       card_valid,
    output logic [7:0] round_no,
    output logic       done
);

    typedef enum logic [1:0] {IDLE, SHOW, HOLD, DONE} state_t;

    state_t      state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d, lfsr_step;
    logic [1:0]  c1_q, c1_d, c2_q, c2_d;
    logic [2:0]  n1_q, n1_d, n2_q, n2_d;
    logic [7:0]  count_q, count_d, round_q, round_d;
    logic        valid_q, valid_d, done_q, done_d;
    logic        deal;

    // Fold 0..7 onto card numbers 1..5 (x mod 5, plus one).
    function automatic logic [2:0] map5(input logic [2:0] x);
        return (x >= 3'd5) ? (x - 3'd4) : (x + 3'd1);
    endfunction

    assign lfsr_step = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        c1_d    = c1_q;
        n1_d    = n1_q;
        c2_d    = c2_q;
        n2_d    = n2_q;
        count_d = count_q;
        round_d = round_q;
        valid_d = valid_q;
        done_d  = done_q;
        deal    = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    round_d = 8'd0;
                    deal    = 1'b1;
                end
            end
            SHOW: begin
                // A press outranks the timeout redeal on the same edge.
                if (finish) begin
                    state_d = HOLD;
                    round_d = round_q + 8'd1;
                    valid_d = 1'b0;
                end else if (count_q == 8'd0) begin
                    deal = 1'b1;
                end else begin
                    count_d = count_q - 8'd1;
                end
            end
            HOLD: begin
                if (!finish) begin
                    if (round_q == MAX_ROUNDS) begin
                        state_d = DONE;
                        c1_d    = 2'd0;
                        n1_d    = 3'd0;
                        c2_d    = 2'd0;
                        n2_d    = 3'd0;
                        count_d = 8'd0;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        deal = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (deal) begin
            state_d = SHOW;
            lfsr_d  = lfsr_step;
            c1_d    = lfsr_step[1:0];
            n1_d    = map5(lfsr_step[4:2]);
            c2_d    = lfsr_step[6:5];
            n2_d    = map5(lfsr_step[9:7]);
            count_d = COUNT_INIT;
            valid_d = 1'b1;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            lfsr_q  <= LFSR_SEED;
            c1_q    <= 2'd0;
            n1_q    <= 3'd0;
            c2_q    <= 2'd0;
            n2_q    <= 3'd0;
            count_q <= 8'd0;
            round_q <= 8'd0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            c1_q    <= c1_d;
            n1_q    <= n1_d;
            c2_q    <= c2_d;
            n2_q    <= n2_d;
            count_q <= count_d;
            round_q <= round_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign c1         = c1_q;
    assign n1         = n1_q;
    assign c2         = c2_q;
    assign n2         = n2_q;
    assign count      = count_q;
    assign card_valid = valid_q;
    assign round_no   = round_q;
    assign done       = done_q;

endmodule

// File: tb/tb_card_dealer.sv
// Self-checking bench for card_dealer: a vector table plus hand-written
// sequences for timeout, press hold, async reset and game end.
module tb_card_dealer;

    localparam logic [15:0] SEED = 16'hACE1;
    localparam int          CINIT = 100;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       finish = 1'b0;
    logic [1:0] c1, c2;
    logic [2:0] n1, n2;
    logic [7:0] count, round_no;
    logic       card_valid, done;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [1:0] c1;
        logic [2:0] n1;
        logic [1:0] c2;
        logic [2:0] n2;
        logic [7:0] count;
        logic       card_valid;
        logic [7:0] round_no;
        logic       done;
    } exp_t;

    typedef struct {
        logic start;
        logic finish;
        exp_t exp;
    } vec_t;

    exp_t        sb_q[$];
    vec_t        vecs[11];
    logic [15:0] model_l;

    card_dealer #(
        .COUNT_INIT(8'd100),
        .MAX_ROUNDS(8'd2),
        .LFSR_SEED (SEED)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .finish    (finish),
        .c1        (c1),
        .n1        (n1),
        .c2        (c2),
        .n2        (n2),
        .count     (count),
        .card_valid(card_valid),
        .round_no  (round_no),
        .done      (done)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    function automatic logic [2:0] map5(input logic [2:0] x);
        int v;
        v = int'(x);
        return 3'((v % 5) + 1);
    endfunction

    function automatic exp_t e_cards(input logic [15:0] l, input int cnt,
                                     input logic valid, input int rnd);
        exp_t e;
        e.c1         = l[1:0];
        e.n1         = map5(l[4:2]);
        e.c2         = l[6:5];
        e.n2         = map5(l[9:7]);
        e.count      = 8'(cnt);
        e.card_valid = valid;
        e.round_no   = 8'(rnd);
        e.done       = 1'b0;
        return e;
    endfunction

    function automatic exp_t e_zero(input int rnd, input logic dn);
        exp_t e;
        e.c1         = 2'd0;
        e.n1         = 3'd0;
        e.c2         = 2'd0;
        e.n2         = 3'd0;
        e.count      = 8'd0;
        e.card_valid = 1'b0;
        e.round_no   = 8'(rnd);
        e.done       = dn;
        return e;
    endfunction

    function automatic vec_t mk_vec(input logic st, input logic fi, input exp_t e);
        vec_t v;
        v.start  = st;
        v.finish = fi;
        v.exp    = e;
        return v;
    endfunction

    function automatic logic [27:0] pack(input exp_t e);
        return {e.c1, e.n1, e.c2, e.n2, e.count, e.card_valid, e.round_no, e.done};
    endfunction

    task automatic compare(input string name);
        exp_t        e;
        logic [27:0] got, want;
        checks++;
        if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL %s scoreboard empty", name);
            return;
        end
        e    = sb_q.pop_front();
        want = pack(e);
        got  = {c1, n1, c2, n2, count, card_valid, round_no, done};
        if (got !== want) begin
            failures++;
            $display("FAIL %s got c1=%0d n1=%0d c2=%0d n2=%0d count=%0d valid=%0b round=%0d done=%0b exp c1=%0d n1=%0d c2=%0d n2=%0d count=%0d valid=%0b round=%0d done=%0b",
                     name, c1, n1, c2, n2, count, card_valid, round_no, done,
                     e.c1, e.n1, e.c2, e.n2, e.count, e.card_valid, e.round_no, e.done);
        end else begin
            $display("ok   %s c1=%0d n1=%0d c2=%0d n2=%0d count=%0d valid=%0b round=%0d done=%0b",
                     name, c1, n1, c2, n2, count, card_valid, round_no, done);
        end
    endtask

    task automatic cyc(input logic st, input logic fi, input exp_t e, input string name);
        start  = st;
        finish = fi;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        compare(name);
    endtask

    initial begin
        logic [15:0] l1, l2, l3;
        l1 = step(SEED);
        l2 = step(l1);
        l3 = step(l2);

        vecs[0]  = mk_vec(1'b0, 1'b0, e_zero(0, 1'b0));
        vecs[1]  = mk_vec(1'b1, 1'b0, e_cards(l1, 100, 1'b1, 0));
        vecs[2]  = mk_vec(1'b0, 1'b0, e_cards(l1, 99, 1'b1, 0));
        vecs[3]  = mk_vec(1'b1, 1'b0, e_cards(l1, 98, 1'b1, 0));
        vecs[4]  = mk_vec(1'b0, 1'b1, e_cards(l1, 98, 1'b0, 1));
        vecs[5]  = mk_vec(1'b0, 1'b1, e_cards(l1, 98, 1'b0, 1));
        vecs[6]  = mk_vec(1'b0, 1'b0, e_cards(l2, 100, 1'b1, 1));
        vecs[7]  = mk_vec(1'b0, 1'b1, e_cards(l2, 100, 1'b0, 2));
        vecs[8]  = mk_vec(1'b0, 1'b0, e_zero(2, 1'b1));
        vecs[9]  = mk_vec(1'b0, 1'b0, e_zero(2, 1'b1));
        vecs[10] = mk_vec(1'b1, 1'b0, e_cards(l3, 100, 1'b1, 0));

        #2;
        sb_q.push_back(e_zero(0, 1'b0));
        compare("reset_state");
        #10 rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 11; i++)
            cyc(vecs[i].start, vecs[i].finish, vecs[i].exp, $sformatf("vec%0d", i));
        model_l = l3;

        cyc(1'b0, 1'b0, e_cards(model_l, 99, 1'b1, 0), "show_count");
        cyc(1'b0, 1'b0, e_cards(model_l, 98, 1'b1, 0), "show_count");

        // Asynchronous reset mid-SHOW, away from any clock edge.
        #2 rst = 1'b0;
        #1;
        sb_q.push_back(e_zero(0, 1'b0));
        compare("async_reset");
        @(posedge clk);
        #1;
        sb_q.push_back(e_zero(0, 1'b0));
        compare("reset_held");
        rst = 1'b1;

        cyc(1'b1, 1'b0, e_cards(16'h59C3, 100, 1'b1, 0), "first_deal");
        model_l = 16'h59C3;
        for (int j = 1; j <= CINIT; j++)
            cyc(1'b0, 1'b0, e_cards(model_l, CINIT - j, 1'b1, 0), "countdown");
        cyc(1'b0, 1'b0, e_cards(16'hB387, 100, 1'b1, 0), "timeout_redeal");
        model_l = 16'hB387;

        for (int j = 1; j <= 43; j++)
            cyc(1'b0, 1'b0, e_cards(model_l, CINIT - j, 1'b1, 0), "countdown2");
        for (int k = 0; k < 3; k++)
            cyc(1'b0, 1'b1, e_cards(model_l, 57, 1'b0, 1), "press_hold");
        model_l = step(model_l);
        cyc(1'b0, 1'b0, e_cards(model_l, 100, 1'b1, 1), "press_redeal");

        for (int j = 1; j <= CINIT; j++)
            cyc(1'b0, 1'b0, e_cards(model_l, CINIT - j, 1'b1, 1), "countdown3");
        cyc(1'b0, 1'b1, e_cards(model_l, 0, 1'b0, 2), "simul_finish");
        cyc(1'b0, 1'b0, e_zero(2, 1'b1), "game_end");
        cyc(1'b0, 1'b0, e_zero(2, 1'b1), "done_hold");

        model_l = step(model_l);
        cyc(1'b1, 1'b0, e_cards(model_l, 100, 1'b1, 0), "restart_deal");
        cyc(1'b1, 1'b0, e_cards(model_l, 99, 1'b1, 0), "start_ignored");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/card_dealer.md
# card_dealer

Card source for the bell game: on `start` it deals a pair of cards to the bell checker (`c1/n1`, `c2/n2`) and runs the 8-bit reward `count` that the score controller latches on a correct press. It redeals when the count times out. It holds the pair while a bell press is being resolved (`finish` high), then deals the next round. After `MAX_ROUNDS` resolved rounds it ends the game. It is the producing end of the card/count interface consumed by the checker and score logic.

## Interface
- `COUNT_INIT`, 8'd100, value loaded into `count` on every deal
- `MAX_ROUNDS`, 8'd10, resolved rounds per game (legal range 1..255)
- `LFSR_SEED`, 16'hACE1, LFSR value after reset; must be nonzero
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `start`  in  1  begin a game; sampled only in IDLE or DONE
- `finish`  in  1  round-resolved flag from score control
- `c1`, `c2`  out  2  card colours, 0..3
- `n1`, `n2`  out  3  card numbers, always 1..5 while `card_valid`=1
- `count`  out  8  reward value, counts down during SHOW
- `card_valid`  out  1  high in SHOW only
- `round_no`  out  8  resolved rounds in the current game
- `done`  out  1  high in DONE only

## Operation
- States:
  - IDLE: reset state.
  - SHOW: cards displayed, `count` running.
  - HOLD: press being resolved; cards and `count` frozen.
  - DONE: game over.
- **LFSR**: 16-bit Fibonacci LFSR. Step rule: new bit = l[15]^l[13]^l[12]^l[10]; l <= {l[14:0], new}. It steps only on a deal, never otherwise.
- **Deal action**: L = stepped LFSR value, registered into the LFSR. The cards are decoded from L:
  - c1 = L[1:0], n1 = map(L[4:2])
  - c2 = L[6:5], n2 = map(L[9:7])
  - map(x) = (x mod 5) + 1, so 0..7 maps to 1,2,3,4,5,1,2,3.
  - The deal also sets `count` = COUNT_INIT and enters SHOW.
- **IDLE**: all outputs 0. When `start`=1: `round_no`<=0, deal.
- **SHOW**, priority order:
  - `finish`=1: go to HOLD; `round_no`<=`round_no`+1; `count` and cards frozen.
  - else `count`==0: deal (timeout redeal); `round_no` unchanged.
  - else `count`<=`count`-1.
- **HOLD**: cards and `count` held stable for the checker/score path; `card_valid`=0. When `finish`=0:
  - if `round_no`==MAX_ROUNDS: go to DONE.
  - else deal.
- **DONE**: `done`=1. Cards, `count` and `card_valid` are 0. `round_no` holds its final value. When `start`=1: `round_no`<=0, deal.
- **Reset values**: `start` is ignored in SHOW and HOLD. Reset (async, any state) forces:
  - state=IDLE, LFSR=LFSR_SEED
  - c1=c2=n1=n2=0, count=0, round_no=0, card_valid=0, done=0
- The LFSR is never reseeded except by reset, so consecutive games continue the sequence.

## Timing
- All outputs are registered and there are no combinational input-to-output paths.
- `start` high at edge k (in IDLE/DONE): cards valid, `count`=COUNT_INIT and `card_valid`=1 after edge k.
- SHOW timeout: a pair dealt at edge k shows `count`=COUNT_INIT-j after edge k+j, reaching 0 after edge k+COUNT_INIT. The redeal happens at edge k+COUNT_INIT+1. Each pair is therefore shown for COUNT_INIT+1 cycles.
- `finish` sampled high at edge m in SHOW: HOLD from edge m; `count` holds the value it had before edge m.
- Simultaneous `finish`=1 and `count`==0: `finish` wins, so the round is resolved and there is no redeal.
- HOLD exit: at the first edge sampling `finish`=0, either the new pair is valid or `done`=1.
- `finish` staying high for several cycles has no further effect. `round_no` increments once per SHOW→HOLD transition.

## Test plan
- **Reset**: assert `rst`=0 mid-SHOW → all outputs 0 immediately (asynchronously); state IDLE; next `start` reproduces the first-deal values below.
- **First deal**: seed 16'hACE1, `start` pulse → LFSR 16'h59C3; c1=3, n1=1, c2=2, n2=4, count=100, card_valid=1.
- **Timeout redeal**: no `finish` → count 100→0 over 100 cycles. The next edge gives LFSR 16'hB387 with c1=3, n1=2, c2=0, n2=3, count=100, round_no still 0.
- **Press resolution**: `finish`=1 for 3 cycles while count=57 → card_valid=0, count stays 57, cards unchanged, round_no=1. On the first edge after `finish`=0, a new pair is dealt and count=100.
- **Simultaneous**: `finish`=1 on the edge where count==0 → HOLD, round_no increments, cards unchanged (no redeal).
- **Game end**: MAX_ROUNDS=2, resolve two rounds → done=1, card_valid=0, count=0, round_no=2. Then `start` → round_no=0 and a deal continues the LFSR sequence without reseeding.
